fir_filter: RTL and testbench
=============================

// Module: fir_filter
// PURPOSE
//  Direct-form, fully parallel FIR filter on a stream of signed 16-bit samples.
//  Each accepted sample produces one filtered output, using run-time coefficients.
//  Sits in the sample datapath between a valid-qualified source and sink.
//  There is no backpressure.
// PARAMETERS
//  TAPS      8   number of coefficients / delay-line depth (>=1)
//  MULTBITS  32  signed product width per tap (>=32, i.e. 16x16 full precision)
//  OUT_SHIFT 0   arithmetic right shift applied to the accumulator before output
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          reset; asynchronous, active-high
//  in_valid    in   1          in_sample is valid this cycle
//  in_sample   in   16         signed two's-complement input sample
//  in_weights  in   16 x TAPS  unpacked array [0:TAPS-1] of signed coefficients
//  out_valid   out  1          out_sample is valid this cycle (1-cycle pulse per result)
//  out_sample  out  16         signed filtered output
// BEHAVIOUR
//  - Reset (async assert) clears:
//    - delay line x[0..TAPS-1] = 0
//    - all pipeline registers = 0
//    - out_valid = 0, out_sample = 0
//  - Delay line:
//    - On a clk edge with in_valid=1: x[0]<=in_sample, x[k]<=x[k-1].
//    - With in_valid=0 the delay line holds.
//  - Math: y = sum_{k=0..TAPS-1} w[k]*x[k], where w[k]=in_weights[k] and x[0] is the newest sample.
//    - Integer arithmetic, all signed.
//    - Each product is sign-extended to MULTBITS.
//    - Accumulator width ACC_W = MULTBITS+$clog2(TAPS); no internal overflow.
//    - Output = sat16(acc >>> OUT_SHIFT): clamp to [-32768, 32767].
//  - Pipeline, fixed latency 2 cycles from the accepting edge:
//    - edge E0: sample enters the delay line.
//    - E1: products register from the updated delay line.
//    - E2: sum, shift and saturate register into out_sample; out_valid=1.
//    - out_valid is in_valid delayed 2 cycles.
//  - Back-to-back valids give one result per cycle. Gaps in in_valid give matching gaps in out_valid.
//  - out_sample holds its last value while out_valid=0.
//  - Weights:
//    - Quasi-static; sampled at the product stage (E1).
//    - A weight change takes effect on the next product-stage edge, with no glitch filtering.
//  - Reset mid-stream:
//    - Flushes all in-flight results; no out_valid pulse for them.
//    - Filtering restarts from zero history.
//  - X or unknown in_valid is treated as not valid only in simulation checks. The RTL does not special-case it.
// STRUCTURE
//  - Package fir_pkg:
//    - SAMPLE_W=16
//    - typedef logic signed [15:0] sample_t
//    - function acc_w(taps, multbits)
//    - function sat16(acc)
//  - Sub-module fir_adder_tree: registered signed sum of TAPS MULTBITS-wide products, output ACC_W.
//  - Top level holds the delay line, multipliers, valid pipeline and output shift/saturate.
// TESTING
//  1. Reset: assert rst async mid-cycle -> out_valid=0 and out_sample=0 immediately.
//     History is zero after release.
//  2. Step response: TAPS=8, w[i]=2i+1, in_sample=1 held with in_valid=1 continuously
//     -> successive outputs 1,4,9,16,25,36,49,64, then 64 steady; first out_valid 2 cycles after first accept.
//  3. Impulse response: w as in 2, one sample=1 then zeros, all valid -> outputs 1,3,5,...,15, then 0.
//  4. Gapped valid: impulse with in_valid toggling 1,0,1,0 -> same value sequence as 3,
//     out_valid pulses mirror the gaps, out_sample holds during gaps.
//  5. Saturation: all w=32767, x=32767 held, OUT_SHIFT=0 -> out_sample=32767.
//     All w=-32768, x=32767 -> -32768.
//  6. Shift: w=[16384, 0...], x=2, OUT_SHIFT=15 -> out_sample=1.
//     Negative x=-2 -> -1 (arithmetic shift).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the fir_filter datapath: sample type,
// accumulator width calculation and 16-bit output saturation.
package fir_pkg;

    localparam int SAMPLE_W = 16;
    // Width of the sat16 argument; callers sign-extend their accumulator into it.
    localparam int SAT_IN_W = 128;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = SAT_IN_W'(32'sd32767);
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = SAT_IN_W'(-32'sd32768);

    function automatic int acc_w(input int taps, input int multbits);
        return multbits + $clog2(taps);
    endfunction

    function automatic sample_t sat16(input logic signed [SAT_IN_W-1:0] acc);
        if (acc > SAT_MAX)
            return 16'sh7fff;
        else if (acc < SAT_MIN)
            return -16'sh8000;
        else
            return sample_t'(acc[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered signed sum of TAPS full-precision products, widened to ACC_W so
// the sum can never overflow.
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int TAPS     = 8,
    parameter int MULTBITS = 32,
    parameter int ACC_W    = acc_w(TAPS, MULTBITS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic signed [MULTBITS-1:0] i_prod [0:TAPS-1],
    output logic signed [ACC_W-1:0]    o_sum
);

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_sum_p2;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++)
            w_sum = w_sum + ACC_W'(i_prod[k]);
    end

    // Stage p2: the sum only moves on a valid result, so the output holds in gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sum_p2 <= '0;
        else if (i_en)
            r_sum_p2 <= w_sum;
    end

    assign o_sum = r_sum_p2;

endmodule

// File: rtl/fir_filter.sv
// Direct-form fully parallel FIR: delay line, registered products, registered
// adder tree, then arithmetic shift and saturation to a 16-bit output.
module fir_filter
    import fir_pkg::*;
#(
    parameter int TAPS      = 8,
    parameter int MULTBITS  = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    input  logic signed [SAMPLE_W-1:0] in_weights [0:TAPS-1],
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] out_sample
);

    localparam int ACC_W = acc_w(TAPS, MULTBITS);

    logic signed [SAMPLE_W-1:0] r_x_p0    [0:TAPS-1];
    logic signed [MULTBITS-1:0] r_prod_p1 [0:TAPS-1];
    logic                       r_vld_p0;
    logic                       r_vld_p1;
    logic                       r_vld_p2;
    logic signed [ACC_W-1:0]    w_acc_p2;
    logic signed [ACC_W-1:0]    w_shift_p2;

    // Stage p0: delay line, x[0] is the newest accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++)
                r_x_p0[k] <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= in_valid;
            if (in_valid) begin
                r_x_p0[0] <= in_sample;
                for (int k = 1; k < TAPS; k++)
                    r_x_p0[k] <= r_x_p0[k-1];
            end
        end
    end

    // Stage p1: weights are sampled here; operands are sign-extended first so
    // the product keeps full 16x16 precision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++)
                r_prod_p1[k] <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++)
                r_prod_p1[k] <= MULTBITS'(r_x_p0[k]) * MULTBITS'(in_weights[k]);
            r_vld_p1 <= r_vld_p0;
        end
    end

    // Stage p2: summed result and its valid pulse.
    fir_adder_tree #(
        .TAPS     (TAPS),
        .MULTBITS (MULTBITS),
        .ACC_W    (ACC_W)
    ) u_adder_tree (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_vld_p1),
        .i_prod (r_prod_p1),
        .o_sum  (w_acc_p2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_vld_p2 <= 1'b0;
        else
            r_vld_p2 <= r_vld_p1;
    end

    assign w_shift_p2 = w_acc_p2 >>> OUT_SHIFT;
    assign out_sample = sat16(SAT_IN_W'(w_shift_p2));
    assign out_valid  = r_vld_p2;

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: reset, step, impulse, gapped valid,
// saturation and output shift, with hand-computed expected values.
module tb_fir_filter;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic signed [15:0] in_sample;
    logic signed [15:0] w [0:7];
    logic              out_valid0;
    logic signed [15:0] out_sample0;
    logic              out_valid1;
    logic signed [15:0] out_sample1;

    int total = 0;
    int bad   = 0;

    fir_filter #(.TAPS(8), .MULTBITS(32), .OUT_SHIFT(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .in_weights (w),
        .out_valid  (out_valid0),
        .out_sample (out_sample0)
    );

    fir_filter #(.TAPS(8), .MULTBITS(32), .OUT_SHIFT(15)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .in_weights (w),
        .out_valid  (out_valid1),
        .out_sample (out_sample1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs expected after tick t (index t-1), first accept on tick 1.
    int step_exp [0:11] = '{0, 0, 1, 4, 9, 16, 25, 36, 49, 64, 64, 64};
    int step_vld [0:11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int imp_exp  [0:11] = '{0, 0, 1, 3, 5, 7, 9, 11, 13, 15, 0, 0};

    initial begin
        int c;
        int hold;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        for (int k = 0; k < 8; k++) w[k] = 16'(2 * k + 1);

        // Reset state
        tick();
        tick();
        chk("reset_vld", 32'(out_valid0), 0);
        chk("reset_out", 32'(out_sample0), 0);
        rst = 1'b0;
        tick();

        // Step response
        in_valid  = 1'b1;
        in_sample = 16'sd1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk($sformatf("step_vld_t%0d", t), 32'(out_valid0), step_vld[t-1]);
            if (step_vld[t-1] != 0)
                chk($sformatf("step_out_t%0d", t), 32'(out_sample0), step_exp[t-1]);
        end

        // Asynchronous reset mid-stream clears outputs immediately
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_vld", 32'(out_valid0), 0);
        chk("async_rst_out", 32'(out_sample0), 0);
        chk("async_rst_out1", 32'(out_sample1), 0);
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk($sformatf("flush_vld_t%0d", t), 32'(out_valid0), 0);
        end

        // Impulse response from zero history
        in_valid  = 1'b1;
        in_sample = 16'sd1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            in_sample = '0;
            chk($sformatf("imp_vld_t%0d", t), 32'(out_valid0), (t >= 3) ? 1 : 0);
            if (t >= 3)
                chk($sformatf("imp_out_t%0d", t), 32'(out_sample0), imp_exp[t-1]);
        end
        in_valid = 1'b0;
        for (int t = 1; t <= 3; t++) tick();
        chk("drain_vld", 32'(out_valid0), 0);
        chk("drain_hold", 32'(out_sample0), 0);

        // Gapped impulse: valid on even cycles c, output lags by 3 ticks
        hold = 0;
        for (int t = 1; t <= 22; t++) begin
            c         = t - 1;
            in_valid  = (c % 2 == 0) && (c < 20);
            in_sample = (c == 0) ? 16'sd1 : 16'sd0;
            tick();
            c = t - 3;
            if (c >= 0 && c % 2 == 0) begin
                hold = (c / 2 < 8) ? 2 * (c / 2) + 1 : 0;
                chk($sformatf("gap_vld_t%0d", t), 32'(out_valid0), 1);
            end else begin
                chk($sformatf("gap_vld_t%0d", t), 32'(out_valid0), 0);
            end
            chk($sformatf("gap_out_t%0d", t), 32'(out_sample0), hold);
        end
        in_valid = 1'b0;
        tick();

        // Positive saturation
        for (int k = 0; k < 8; k++) w[k] = 16'sd32767;
        in_valid  = 1'b1;
        in_sample = 16'sd32767;
        for (int t = 1; t <= 10; t++) tick();
        chk("sat_pos_vld", 32'(out_valid0), 1);
        chk("sat_pos_out", 32'(out_sample0), 32767);

        // Negative saturation after a weight change
        for (int k = 0; k < 8; k++) w[k] = -16'sd32768;
        for (int t = 1; t <= 3; t++) tick();
        chk("sat_neg_out", 32'(out_sample0), -32768);

        // Output shift: only w[0] is non-zero, so only the newest sample matters
        w[0] = 16'sd16384;
        for (int k = 1; k < 8; k++) w[k] = '0;
        in_sample = 16'sd2;
        for (int t = 1; t <= 3; t++) tick();
        chk("shift_pos_out1", 32'(out_sample1), 1);
        chk("shift_pos_vld1", 32'(out_valid1), 1);
        chk("noshift_pos_sat", 32'(out_sample0), 32767);
        in_sample = -16'sd2;
        for (int t = 1; t <= 3; t++) tick();
        chk("shift_neg_out1", 32'(out_sample1), -1);
        chk("noshift_neg_edge", 32'(out_sample0), -32768);

        in_valid = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
